// File: rtl/stopwatch_counter_pkg.sv
// Shared types, digit limits and width helper for the BCD stopwatch.
// Imported by the interface, the digit cell and the top level.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t TENTHS_MAX   = 4'd9;
    localparam bcd_t SEC_ONES_MAX = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_MAX      = 4'd9;

    function automatic int stopwatch_w(int min_digits);
        return 4 * (3 + min_digits);
    endfunction

    // Roll-over limit of the digit at position idx, LSB digit first.
    function automatic bcd_t digit_limit(int idx);
        bcd_t lim;
        case (idx)
            0:       lim = TENTHS_MAX;
            1:       lim = SEC_ONES_MAX;
            2:       lim = SEC_TENS_MAX;
            default: lim = MIN_MAX;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control/display bundle of the stopwatch counter.
// master = control FSM side, slave = counter side.
interface stopwatch_counter_if
    import stopwatch_pkg::*;
#(
    parameter int MIN_DIGITS = 2
) ();

    localparam int W = stopwatch_w(MIN_DIGITS);

    logic         tick;
    logic         run;
    logic         dir;
    logic         load;
    logic [W-1:0] preset;
    logic         lap_capture;
    logic [W-1:0] count;
    logic [W-1:0] lap;
    logic         zero;
    logic         wrap;
    logic         done;

    modport master (
        output tick, run, dir, load, preset, lap_capture,
        input  count, lap, zero, wrap, done
    );

    modport slave (
        input  tick, run, dir, load, preset, lap_capture,
        output count, lap, zero, wrap, done
    );

endinterface

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit with clamped load, carry/borrow in and out.
// step_out fires when this digit rolls over (up) or borrows (down).
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t LIMIT = 4'd9
) (
    input  logic clk,
    input  logic rst,
    input  logic step_in,
    input  logic dir,
    input  logic load,
    input  bcd_t load_val,
    output bcd_t q,
    output logic step_out
);

    bcd_t q_n;
    logic up;
    logic dn;

    assign up = step_in && !load && !dir;
    assign dn = step_in && !load && dir;

    always_comb begin
        q_n = q;
        unique case (1'b1)
            load: q_n = (load_val > LIMIT) ? LIMIT : load_val;
            up:   q_n = (q == LIMIT) ? 4'd0 : q + 4'd1;
            dn:   q_n = (q == 4'd0) ? LIMIT : q - 4'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 4'd0;
        else     q <= q_n;
    end

    assign step_out = step_in && (dir ? (q == 4'd0) : (q == LIMIT));

endmodule

// File: rtl/stopwatch_counter.sv
// BCD elapsed-time counter: tenths, seconds, MIN_DIGITS minute digits.
// Optional lap register built when STOPWATCH_LAP_EN is defined.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MIN_DIGITS  = 2,
    parameter bit SATURATE_UP = 1'b0
) (
    input logic                clk,
    input logic                rst,
    stopwatch_counter_if.slave bus
);

    localparam int ND = 3 + MIN_DIGITS;
    localparam int W  = stopwatch_w(MIN_DIGITS);

    logic [W-1:0]  cnt;
    logic [ND:0]   carry;
    logic [ND-1:0] at_lim;
    logic          is_max;
    logic          is_one;
    logic          blocked;
    logic          step_eff;
    logic          zero_q, zero_n;
    logic          wrap_q, wrap_n;
    logic          done_q, done_n;

    // Down-count parks at zero; saturating up-count parks at max.
    assign blocked  = bus.dir ? zero_q : (SATURATE_UP && is_max);
    assign step_eff = bus.tick && bus.run && !bus.load && !blocked;
    assign carry[0] = step_eff;

    for (genvar i = 0; i < ND; i++) begin : g_dig
        bcd_digit #(
            .LIMIT(digit_limit(i))
        ) u_dig (
            .clk     (clk),
            .rst     (rst),
            .step_in (carry[i]),
            .dir     (bus.dir),
            .load    (bus.load),
            .load_val(bus.preset[4*i +: 4]),
            .q       (cnt[4*i +: 4]),
            .step_out(carry[i+1])
        );
        assign at_lim[i] = (cnt[4*i +: 4] == digit_limit(i));
    end

    assign is_max = &at_lim;
    assign is_one = (cnt == W'(1));

    always_comb begin
        zero_n = zero_q;
        wrap_n = 1'b0;
        done_n = 1'b0;
        if (bus.load) begin
            // Clamping never turns a nonzero digit into zero.
            zero_n = (bus.preset == '0);
        end else if (step_eff) begin
            wrap_n = carry[ND] && !bus.dir;
            done_n = bus.dir && is_one;
            zero_n = wrap_n || done_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b1;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            zero_q <= zero_n;
            wrap_q <= wrap_n;
            done_q <= done_n;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [W-1:0] lap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  lap_q <= '0;
        else if (bus.lap_capture) lap_q <= cnt;
    end

    assign bus.lap = lap_q;
`else
    logic unused_lap_capture;

    assign unused_lap_capture = bus.lap_capture;
    assign bus.lap            = '0;
`endif

    assign bus.count = cnt;
    assign bus.zero  = zero_q;
    assign bus.wrap  = wrap_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench: wrapping DUT plus a saturating twin on the same stimulus.
// Lap expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    stopwatch_counter_if #(.MIN_DIGITS(2)) bw ();
    stopwatch_counter_if #(.MIN_DIGITS(2)) bs ();

    stopwatch_counter #(
        .MIN_DIGITS (2),
        .SATURATE_UP(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bw)
    );

    stopwatch_counter #(
        .MIN_DIGITS (2),
        .SATURATE_UP(1'b1)
    ) dut_s (
        .clk(clk),
        .rst(rst),
        .bus(bs)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(logic t, logic r, logic d, logic l,
                         logic [19:0] p, logic lc);
        bw.tick = t; bw.run = r; bw.dir = d;
        bw.load = l; bw.preset = p; bw.lap_capture = lc;
        bs.tick = t; bs.run = r; bs.dir = d;
        bs.load = l; bs.preset = p; bs.lap_capture = lc;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(logic [19:0] p);
        drive(0, 0, 0, 1, p, 0);
        cyc();
        drive(0, 0, 0, 0, 20'h0, 0);
    endtask

    task automatic status(string tag, logic [19:0] c,
                          logic z, logic w, logic d);
        check({tag, ".count"}, 32'(bw.count), 32'(c));
        check({tag, ".zero"},  32'(bw.zero),  32'(z));
        check({tag, ".wrap"},  32'(bw.wrap),  32'(w));
        check({tag, ".done"},  32'(bw.done),  32'(d));
    endtask

    logic [19:0] lap_exp;

    initial begin
        drive(0, 0, 0, 0, 20'h0, 0);
        cyc();
        status("rst", 20'h0, 1, 0, 0);
        check("rst.lap", 32'(bw.lap), 32'h0);
        rst = 1'b0;
        cyc();

        // Carry 00:59.9 -> 01:00.0
        do_load(20'h00599);
        status("ld599", 20'h00599, 0, 0, 0);
        drive(1, 1, 0, 0, 20'h0, 0);
        cyc();
        drive(0, 1, 0, 0, 20'h0, 0);
        status("carry", 20'h01000, 0, 0, 0);

        // Borrow 01:00.0 -> 00:59.9
        drive(1, 1, 1, 0, 20'h0, 0);
        cyc();
        drive(0, 1, 1, 0, 20'h0, 0);
        status("borrow", 20'h00599, 0, 0, 0);

        // Maximum: wrap vs saturate
        do_load(20'h99599);
        drive(1, 1, 0, 0, 20'h0, 0);
        cyc();
        drive(0, 1, 0, 0, 20'h0, 0);
        status("wrap", 20'h0, 1, 1, 0);
        check("sat.count", 32'(bs.count), 32'h99599);
        check("sat.wrap",  32'(bs.wrap),  32'h0);
        cyc();
        check("wrap.pulse1", 32'(bw.wrap), 32'h0);

        // Down to zero, then parked
        do_load(20'h00002);
        drive(1, 1, 1, 0, 20'h0, 0);
        cyc();
        status("dn1", 20'h00001, 0, 0, 0);
        cyc();
        status("dn0", 20'h0, 1, 0, 1);
        cyc();
        drive(0, 1, 1, 0, 20'h0, 0);
        status("dnpark", 20'h0, 1, 0, 0);

        // Back-to-back up, then direction change
        drive(1, 1, 0, 0, 20'h0, 0);
        cyc();
        cyc();
        cyc();
        status("b2b", 20'h00003, 0, 0, 0);
        drive(1, 1, 1, 0, 20'h0, 0);
        cyc();
        drive(0, 1, 1, 0, 20'h0, 0);
        status("dirchg", 20'h00002, 0, 0, 0);

        // run low freezes count
        drive(1, 0, 0, 0, 20'h0, 0);
        cyc();
        cyc();
        status("frozen", 20'h00002, 0, 0, 0);

        // Load priority over tick, with clamping
        drive(1, 1, 0, 1, 20'h0A70C, 0);
        cyc();
        drive(0, 0, 0, 0, 20'h0, 0);
        status("clamp", 20'h09509, 0, 0, 0);

        // Load of zero gives no pulse
        drive(0, 0, 1, 1, 20'h0, 0);
        cyc();
        drive(0, 0, 0, 0, 20'h0, 0);
        status("ldzero", 20'h0, 1, 0, 0);

        // Lap capture alongside a step
        do_load(20'h00105);
        drive(1, 1, 0, 0, 20'h0, 1);
        cyc();
        drive(0, 0, 0, 0, 20'h0, 0);
`ifdef STOPWATCH_LAP_EN
        lap_exp = 20'h00105;
`else
        lap_exp = 20'h0;
`endif
        status("lapstep", 20'h00106, 0, 0, 0);
        check("lap", 32'(bw.lap), 32'(lap_exp));

        // Async reset mid-count
        do_load(20'h01234);
        drive(1, 1, 0, 0, 20'h0, 0);
        cyc();
        check("pre_rst", 32'(bw.count), 32'h01235);
        #2;
        rst = 1'b1;
        #1;
        check("arst.count", 32'(bw.count), 32'h0);
        check("arst.zero",  32'(bw.zero),  32'h1);
        cyc();
        status("arst.hold", 20'h0, 1, 0, 0);
        drive(0, 0, 0, 0, 20'h0, 0);
        rst = 1'b0;
        cyc();
        status("post_rst", 20'h0, 1, 0, 0);
        check("post_rst.lap", 32'(bw.lap), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
